// File: rtl/stochastic_number_generator.sv
// Stochastic number generator: 4-bit LFSR feeding three decorrelated
// comparators whose AND forms a product-density bit stream.
//
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset (L <= SEED, SBS <= 0)
//   X1..X3     4-bit unsigned operands, sampled every edge
//   L          registered LFSR state (x^4+x^3+1, period 15)
//   SBS        registered stream bit, B1&B2&B3 of the previous L
module stochastic_number_generator #(
  parameter logic [4:1] SEED = 4'b0001
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [4:1] X1,
  input  logic [4:1] X2,
  input  logic [4:1] X3,
  output logic [4:1] L,
  output logic       SBS
);

  logic [4:1] lfsr_q;
  logic [4:1] lfsr_d;
  logic       sbs_q;
  logic       sbs_d;

  logic [4:1] r1;
  logic [4:1] r2;
  logic [4:1] r3;
  logic       b1;
  logic       b2;
  logic       b3;

  always_comb begin
    r1 = lfsr_q;
    r2 = {lfsr_q[3:1], lfsr_q[4]};
    r3 = {lfsr_q[1], lfsr_q[2],
          lfsr_q[3], lfsr_q[4]};
    b1 = (r1 < X1);
    b2 = (r2 < X2);
    b3 = (r3 < X3);
    sbs_d = b1 & b2 & b3;
    // all-zero state never leaves by itself;
    // reload the seed to escape it
    if (lfsr_q == 4'b0000) begin
      lfsr_d = SEED;
    end else begin
      lfsr_d = {lfsr_q[3:1],
                lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= SEED;
      sbs_q  <= 1'b0;
    end else begin
      lfsr_q <= lfsr_d;
      sbs_q  <= sbs_d;
    end
  end

  assign L   = lfsr_q;
  assign SBS = sbs_q;

endmodule

// File: tb/tb_stochastic_number_generator.sv
// Directed bench for stochastic_number_generator: vector table
// plus hand-written density, reset and latency sequences.
module tb_stochastic_number_generator;

  logic       clk;
  logic       rst;
  logic [4:1] x1;
  logic [4:1] x2;
  logic [4:1] x3;
  logic [4:1] l;
  logic       sbs;

  int errors;
  int checks;

  typedef struct {
    logic       rst;
    logic [3:0] x1;
    logic [3:0] x2;
    logic [3:0] x3;
    logic [3:0] l;
    logic       sbs;
  } vec_t;

  vec_t tbl[$];

  // expected LFSR sequence from SEED=0001
  logic [3:0] seq [15] = '{
    4'd1, 4'd2, 4'd4, 4'd9, 4'd3,
    4'd6, 4'd13, 4'd10, 4'd5, 4'd11,
    4'd7, 4'd15, 4'd14, 4'd12, 4'd8
  };

  stochastic_number_generator #(
    .SEED(4'b0001)
  ) dut (
    .clk(clk),
    .rst(rst),
    .X1 (x1),
    .X2 (x2),
    .X3 (x3),
    .L  (l),
    .SBS(sbs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(
    input string name,
    input int    act,
    input int    exp
  );
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d",
               name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(
    input logic       r,
    input logic [3:0] a,
    input logic [3:0] b,
    input logic [3:0] c
  );
    rst = r;
    x1  = a;
    x2  = b;
    x3  = c;
  endtask

  task automatic do_reset();
    drive(1'b1, 4'd0, 4'd0, 4'd0);
    tick();
    rst = 1'b0;
  endtask

  initial begin
    int ones;
    errors = 0;
    checks = 0;
    drive(1'b1, 4'd0, 4'd0, 4'd0);

    // reset held two edges
    tbl.push_back('{1'b1, 4'd0, 4'd0, 4'd0,
                    4'd1, 1'b0});
    tbl.push_back('{1'b1, 4'd0, 4'd0, 4'd0,
                    4'd1, 1'b0});
    // 15-state walk and wrap at edge 16
    for (int k = 1; k <= 16; k++)
      tbl.push_back('{1'b0, 4'd0, 4'd0, 4'd0,
                      seq[k % 15], 1'b0});
    // comparator edges from a fresh reset
    tbl.push_back('{1'b1, 4'd0, 4'd0, 4'd0,
                    4'd1, 1'b0});
    // L=1: R=1,2,8
    tbl.push_back('{1'b0, 4'd2, 4'd3, 4'd9,
                    4'd2, 1'b1});
    // L=2: R1=2 not < 2
    tbl.push_back('{1'b0, 4'd2, 4'd5, 4'd5,
                    4'd4, 1'b0});
    // L=4: R=4,8,2
    tbl.push_back('{1'b0, 4'd5, 4'd9, 4'd3,
                    4'd9, 1'b1});
    // L=9: R2=3 not < 3
    tbl.push_back('{1'b0, 4'd10, 4'd3, 4'd10,
                    4'd3, 1'b0});
    // L=3: R=3,6,12
    tbl.push_back('{1'b0, 4'd4, 4'd7, 4'd13,
                    4'd6, 1'b1});
    // L=6: R3=6, X3=0 forces zero
    tbl.push_back('{1'b0, 4'd15, 4'd15, 4'd0,
                    4'd13, 1'b0});

    foreach (tbl[i]) begin
      drive(tbl[i].rst, tbl[i].x1,
            tbl[i].x2, tbl[i].x3);
      tick();
      check($sformatf("tbl%0d_L", i),
            int'(l), int'(tbl[i].l));
      check($sformatf("tbl%0d_SBS", i),
            int'(sbs), int'(tbl[i].sbs));
    end

    // mid-stream reset at L=1011
    do_reset();
    for (int k = 1; k <= 9; k++) tick();
    check("mid_pre_L", int'(l), 11);
    rst = 1'b1;
    tick();
    check("mid_rst_L", int'(l), 1);
    check("mid_rst_SBS", int'(sbs), 0);

    // full scale: 14 ones per period
    do_reset();
    drive(1'b0, 4'd15, 4'd15, 4'd15);
    ones = 0;
    for (int k = 1; k <= 30; k++) begin
      tick();
      check($sformatf("fs_e%0d", k), int'(sbs),
            (seq[(k - 1) % 15] != 4'd15) ? 1 : 0);
      if (k >= 8 && k <= 22) ones += int'(sbs);
    end
    check("fs_ones", ones, 14);

    // X1=8: ones after L in 1..7
    do_reset();
    drive(1'b0, 4'd8, 4'd15, 4'd15);
    ones = 0;
    for (int k = 1; k <= 15; k++) begin
      tick();
      check($sformatf("half_e%0d", k), int'(sbs),
            (seq[(k - 1) % 15] < 4'd8) ? 1 : 0);
      ones += int'(sbs);
    end
    check("half_ones", ones, 7);

    // correlated operands never all pass
    do_reset();
    drive(1'b0, 4'd7, 4'd5, 4'd4);
    ones = 0;
    for (int k = 1; k <= 15; k++) begin
      tick();
      ones += int'(sbs);
    end
    check("corr_ones", ones, 0);

    // operand change latency
    do_reset();
    drive(1'b0, 4'd15, 4'd15, 4'd15);
    tick();
    check("chg_first", int'(sbs), 1);
    x1 = 4'd0;
    for (int k = 1; k <= 5; k++) begin
      tick();
      check($sformatf("chg_e%0d", k),
            int'(sbs), 0);
    end

    $display("Result: errors=%0d of %0d checks",
             errors, checks);
    $finish;
  end

endmodule
